// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the VGA display path (640x480@60 Hz from 50 MHz).
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_CLK_DIV  = 2;

  localparam bit SYNC_ACT_LOW  = 1'b0;
  localparam bit SYNC_ACT_HIGH = 1'b1;
  localparam bit VGA_HS_POL    = SYNC_ACT_LOW;
  localparam bit VGA_VS_POL    = SYNC_ACT_LOW;

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int VGA_H_TOTAL = vga_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
  localparam int VGA_V_TOTAL = vga_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate clock enable: one registered clk-wide pulse every CLK_DIV clks.
module vga_pix_div
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      pix_en  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + CW'(1);
      pix_en  <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing: pixel enable, H/V counters, sync/display decode and line/frame strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = VGA_HS_POL,
  parameter bit VS_POL   = VGA_VS_POL,
  parameter int CLK_DIV  = VGA_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_en,
  output logic [9:0] CounterX,
  output logic [9:0] CounterY,
  output logic       inDisplayArea,
  output logic       vga_h_sync,
  output logic       vga_v_sync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_cfg
    $error("vga_timing_gen: totals must fit in 10 bits and CLK_DIV must be >= 1");
  end

  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  // Thresholds are one bit wider so a sync window ending exactly at 1024 still decodes.
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  x_nxt, y_nxt;
  logic [10:0] x_ext, y_ext;
  logic        x_wrap, y_wrap;

  vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en)
  );

  always_comb begin
    x_nxt  = CounterX + 10'd1;
    y_nxt  = CounterY;
    x_wrap = 1'b0;
    y_wrap = 1'b0;
    if (CounterX == H_LAST) begin
      x_nxt  = '0;
      x_wrap = 1'b1;
      if (CounterY == V_LAST) begin
        y_nxt  = '0;
        y_wrap = 1'b1;
      end else begin
        y_nxt = CounterY + 10'd1;
      end
    end
    x_ext = {1'b0, x_nxt};
    y_ext = {1'b0, y_nxt};
  end

  // Flags are decoded from the next counter values so they land with the coordinates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CounterX      <= '0;
      CounterY      <= '0;
      inDisplayArea <= 1'b0;
      vga_h_sync    <= ~HS_POL;
      vga_v_sync    <= ~VS_POL;
      line_start    <= 1'b0;
      frame_start   <= 1'b0;
    end else if (pix_en) begin
      CounterX      <= x_nxt;
      CounterY      <= y_nxt;
      inDisplayArea <= (x_ext < H_ACT) && (y_ext < V_ACT);
      vga_h_sync    <= (x_ext >= HS_BEG && x_ext < HS_END) ? HS_POL : ~HS_POL;
      vga_v_sync    <= (y_ext >= VS_BEG && y_ext < VS_END) ? VS_POL : ~VS_POL;
      line_start    <= x_wrap;
      frame_start   <= y_wrap;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing, a tiny raster, and a narrow-line/default-vertical raster.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  logic       d_pix, d_ida, d_hs, d_vs, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_pix, s_ida, s_hs, s_vs, s_ls, s_fs;
  logic [9:0] s_x, s_y;
  logic       m_pix, m_ida, m_hs, m_vs, m_ls, m_fs;
  logic [9:0] m_x, m_y;

  always #5 clk = ~clk;

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .pix_en(d_pix), .CounterX(d_x), .CounterY(d_y),
    .inDisplayArea(d_ida), .vga_h_sync(d_hs), .vga_v_sync(d_vs),
    .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .pix_en(s_pix), .CounterX(s_x), .CounterY(s_y),
    .inDisplayArea(s_ida), .vga_h_sync(s_hs), .vga_v_sync(s_vs),
    .line_start(s_ls), .frame_start(s_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .CLK_DIV(1)
  ) u_mid (
    .clk(clk), .rst_n(rst_n), .pix_en(m_pix), .CounterX(m_x), .CounterY(m_y),
    .inDisplayArea(m_ida), .vga_h_sync(m_hs), .vga_v_sync(m_vs),
    .line_start(m_ls), .frame_start(m_fs)
  );

  // Leaves the bench on a negedge with zero posedges seen since release.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [25:0] act, exp;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    act = {d_pix, d_x, d_y, d_ida, d_hs, d_vs, d_ls, d_fs};
    exp = {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    n_total++;
    if (act !== exp) $display("FAIL reset_def: got %h expected %h", act, exp);
    else n_pass++;
    n_total++;
    if ({s_hs, s_vs, s_ida, s_ls, s_fs} !== 5'b00000)
      $display("FAIL reset_small_pol: got %b expected 00000", {s_hs, s_vs, s_ida, s_ls, s_fs});
    else n_pass++;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_total++;
    if (d_x !== 10'd9 || m_x !== 10'd3)
      $display("FAIL run_pre_async: got d_x=%0d m_x=%0d expected 9 3", d_x, m_x);
    else n_pass++;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    act = {d_pix, d_x, d_y, d_ida, d_hs, d_vs, d_ls, d_fs};
    n_total++;
    if (act !== exp) $display("FAIL async_reset_def: got %h expected %h", act, exp);
    else n_pass++;
    n_total++;
    if (m_x !== 10'd0 || m_pix !== 1'b0)
      $display("FAIL async_reset_mid: got x=%0d pix=%b expected 0 0", m_x, m_pix);
    else n_pass++;
  endtask

  task automatic test_divider();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_total++;
      if (d_pix !== ((k % 2) == 0) || d_x !== 10'((k - 1) / 2))
        $display("FAIL div2_k%0d: got pix=%b x=%0d expected pix=%b x=%0d",
                 k, d_pix, d_x, ((k % 2) == 0), (k - 1) / 2);
      else n_pass++;
      n_total++;
      if (s_pix !== 1'b1 || s_x !== 10'((k - 1) % 8))
        $display("FAIL div1_k%0d: got pix=%b x=%0d expected pix=1 x=%0d", k, s_pix, s_x, (k - 1) % 8);
      else n_pass++;
    end
  endtask

  task automatic test_horizontal();
    logic [9:0] prev_x;
    logic       prev_ida, fall_ok, ls_ok;
    int run, run_err, ida_err, hs_cnt, hs_min, hs_max, ls_cnt, fs_cnt;
    prev_x = '0; prev_ida = 1'b0; fall_ok = 1'b0; ls_ok = 1'b0;
    run = 0; run_err = 0; ida_err = 0; hs_cnt = 0; hs_min = 9999; hs_max = -1;
    ls_cnt = 0; fs_cnt = 0;
    do_reset();
    for (int k = 1; k <= 1610; k++) begin
      @(negedge clk);
      if (d_ida !== ((d_x < 10'd640) && !(d_x == 10'd0 && d_y == 10'd0))) ida_err++;
      if (d_x != prev_x) begin
        if (run != 2) run_err++;
        run = 1;
      end else run++;
      if (prev_x == 10'd639 && d_x == 10'd640) fall_ok = prev_ida && !d_ida;
      if (!d_hs) begin
        hs_cnt++;
        if (int'(d_x) < hs_min) hs_min = int'(d_x);
        if (int'(d_x) > hs_max) hs_max = int'(d_x);
      end
      if (d_ls) begin
        ls_cnt++;
        ls_ok = (d_x == 10'd0) && (prev_x == 10'd799) && (d_y == 10'd1);
      end
      if (d_fs) fs_cnt++;
      prev_x = d_x;
      prev_ida = d_ida;
    end
    n_total++;
    if (ida_err != 0) $display("FAIL h_ida_pattern: got %0d bad samples expected 0", ida_err);
    else n_pass++;
    n_total++;
    if (run_err != 0) $display("FAIL h_hold_2clk: got %0d bad runs expected 0", run_err);
    else n_pass++;
    n_total++;
    if (!fall_ok) $display("FAIL h_ida_fall_640: got %b expected 1", fall_ok);
    else n_pass++;
    n_total++;
    if (hs_cnt != 192 || hs_min != 656 || hs_max != 751)
      $display("FAIL h_sync_window: got cnt=%0d min=%0d max=%0d expected 192 656 751", hs_cnt, hs_min, hs_max);
    else n_pass++;
    n_total++;
    if (ls_cnt != 1 || !ls_ok)
      $display("FAIL h_line_start: got cnt=%0d ok=%b expected 1 1", ls_cnt, ls_ok);
    else n_pass++;
    n_total++;
    if (fs_cnt != 0) $display("FAIL h_no_frame_start: got %0d expected 0", fs_cnt);
    else n_pass++;
  endtask

  task automatic test_vertical();
    logic [9:0] prev_y;
    logic       fs_ok;
    int vs_cnt, vs_min, vs_max, ida_err, ida_cnt, fs_cnt;
    prev_y = '0; fs_ok = 1'b0;
    vs_cnt = 0; vs_min = 9999; vs_max = -1; ida_err = 0; ida_cnt = 0; fs_cnt = 0;
    do_reset();
    for (int k = 1; k <= 4210; k++) begin
      @(negedge clk);
      if (!m_vs) begin
        vs_cnt++;
        if (int'(m_y) < vs_min) vs_min = int'(m_y);
        if (int'(m_y) > vs_max) vs_max = int'(m_y);
      end
      if (m_ida && m_y >= 10'd480) ida_err++;
      if (m_ida && k <= 4200) ida_cnt++;
      if (m_fs) begin
        fs_cnt++;
        fs_ok = (k == 4201) && (m_x == 10'd0) && (m_y == 10'd0) && m_ls && (prev_y == 10'd524);
      end
      prev_y = m_y;
    end
    n_total++;
    if (vs_cnt != 16 || vs_min != 490 || vs_max != 491)
      $display("FAIL v_sync_window: got cnt=%0d min=%0d max=%0d expected 16 490 491", vs_cnt, vs_min, vs_max);
    else n_pass++;
    n_total++;
    if (ida_err != 0) $display("FAIL v_blank_ida: got %0d samples expected 0", ida_err);
    else n_pass++;
    n_total++;
    if (ida_cnt != 1919) $display("FAIL v_ida_count: got %0d expected 1919", ida_cnt);
    else n_pass++;
    n_total++;
    if (fs_cnt != 1 || !fs_ok) $display("FAIL v_frame_start: got cnt=%0d ok=%b expected 1 1", fs_cnt, fs_ok);
    else n_pass++;
  endtask

  task automatic test_small();
    logic [26:0] act, exp;
    int ex, ey;
    do_reset();
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      ex = (k - 1) % 8;
      ey = ((k - 1) / 8) % 6;
      exp = {1'b1, 10'(ex), 10'(ey), (ex == 5 || ex == 6), (ey == 4),
             (k > 1 && ex < 4 && ey < 3), (k > 1 && ex == 0), (k > 1 && ex == 0 && ey == 0)};
      act = {s_pix, s_x, s_y, s_hs, s_vs, s_ida, s_ls, s_fs};
      n_total++;
      if (act !== exp) $display("FAIL small_k%0d: got %h expected %h", k, act, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midframe();
    int fs_cnt, fs_k, ls_k;
    fs_cnt = 0; fs_k = -1; ls_k = -1;
    do_reset();
    repeat (1606) @(negedge clk);
    n_total++;
    if (m_x !== 10'd5 || m_y !== 10'd200)
      $display("FAIL mid_position: got x=%0d y=%0d expected 5 200", m_x, m_y);
    else n_pass++;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({m_x, m_y, m_ida, m_hs, m_vs, m_ls, m_fs} !== {10'd0, 10'd0, 5'b01100})
      $display("FAIL mid_async_reset: got x=%0d y=%0d flags=%b expected 0 0 01100",
               m_x, m_y, {m_ida, m_hs, m_vs, m_ls, m_fs});
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4202; k++) begin
      @(negedge clk);
      if (m_fs) begin
        fs_cnt++;
        if (fs_k < 0) fs_k = k;
      end
      if (m_ls && ls_k < 0) ls_k = k;
      if (k == 2) begin
        n_total++;
        if (m_x !== 10'd1 || m_y !== 10'd0)
          $display("FAIL mid_restart: got x=%0d y=%0d expected 1 0", m_x, m_y);
        else n_pass++;
      end
    end
    n_total++;
    if (ls_k != 9) $display("FAIL mid_first_line_start: got k=%0d expected 9", ls_k);
    else n_pass++;
    n_total++;
    if (fs_cnt != 1 || fs_k != 4201)
      $display("FAIL mid_first_frame_start: got cnt=%0d k=%0d expected 1 4201", fs_cnt, fs_k);
    else n_pass++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_divider();
    test_horizontal();
    test_vertical();
    test_small();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
